// File: rtl/uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART transmit arbiter slice.
//   state_e         : arbiter FSM state encoding (IDLE=0, LAUNCH=1, WAIT_DONE=2)
//   *_DEF           : default parameter values
//   rr_next()       : round-robin successor of a requester index
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   localparam int NUM_REQ_DEF     = 4;
   localparam int DATA_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 2048;

   // Successor of id in a ring of n requesters; n need not be a power of 2.
   function automatic int rr_next(input int id, input int n);
      if (id >= n - 1) begin
         return 0;
      end else begin
         return id + 1;
      end
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake, the transmitter start/data/done port and
// the arbiter status outputs.
//   master : arbiter view (drives ready/done/tx_start/tx_data/status)
//   slave  : environment view (requesters + transmitter)
// Signals:
//   req_valid[NUM_REQ], req_data[NUM_REQ*DATA_W], req_ready[NUM_REQ],
//   req_done[NUM_REQ], tx_start, tx_data[DATA_W], tx_done, busy,
//   grant_id[$clog2(NUM_REQ)], timeout_err
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_done;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_done;
   logic                      busy;
   logic [IDX_W-1:0]          grant_id;
   logic                      timeout_err;

   modport master (
      input  req_valid, req_data, tx_done,
      output req_ready, req_done, tx_start, tx_data, busy, grant_id, timeout_err
   );

   modport slave (
      output req_valid, req_data, tx_done,
      input  req_ready, req_done, tx_start, tx_data, busy, grant_id, timeout_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: scans req starting at rr_ptr, wrapping
// modulo NUM_REQ, and reports the first set bit.
//   req    in  NUM_REQ  request vector
//   rr_ptr in  IDX_W    highest-priority index for this scan (< NUM_REQ)
//   found  out 1        at least one request set
//   winner out IDX_W    selected index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = $clog2(NUM_REQ_DEF)
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   winner
);

   logic [IDX_W:0] sum_s;
   logic [IDX_W:0] slot_s;
   logic           hit_s;

   // Walk the ring from rr_ptr; the first hit locks the result.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum_s  = '0;
      slot_s = '0;
      hit_s  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum_s  = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         // rr_ptr < NUM_REQ, so one conditional subtract performs the wrap.
         slot_s = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? (sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s;
         hit_s  = !found && req[slot_s[IDX_W-1:0]];
         winner = hit_s ? slot_s[IDX_W-1:0] : winner;
         found  = found | hit_s;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers. A granted byte is latched, tx_start is pulsed, and the arbiter
// waits for tx_done; a watchdog aborts the frame if tx_done never comes.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    uart_tx_arbiter_if.master (requester handshake, transmitter port,
//          busy / grant_id / timeout_err status); all outputs registered
// ---------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
   input  logic                clk,
   input  logic                reset,
   uart_tx_arbiter_if.master   bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // A disabled watchdog still gets a 1-bit counter so every width stays legal.
   localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam bit WD_EN = (TIMEOUT_CYC != 0);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [WD_W-1:0] WD_MAX  = '1;

   state_e             state_r;
   logic [IDX_W-1:0]   rr_ptr_r;
   logic [IDX_W-1:0]   grant_id_r;
   logic [DATA_W-1:0]  tx_data_r;
   logic [NUM_REQ-1:0] req_ready_r;
   logic [NUM_REQ-1:0] req_done_r;
   logic               tx_start_r;
   logic               busy_r;
   logic               timeout_err_r;
   logic [WD_W-1:0]    wd_cnt_r;

   logic               found_s;
   logic [IDX_W-1:0]   winner_s;
   logic [IDX_W-1:0]   next_ptr_s;
   logic [DATA_W-1:0]  sel_data_s;
   logic [NUM_REQ-1:0] grant_hot_s;
   logic [NUM_REQ-1:0] winner_hot_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req     (bus.req_valid),
      .rr_ptr  (rr_ptr_r),
      .found   (found_s),
      .winner  (winner_s)
   );

   assign next_ptr_s   = IDX_W'(rr_next(int'(grant_id_r), NUM_REQ));
   assign grant_hot_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
   assign winner_hot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;

   // Byte of the current round-robin winner.
   always_comb begin
      sel_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_data_s = (winner_s == IDX_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W] : sel_data_s;
      end
   end

   // Arbiter FSM with grant/data latches, pulse outputs and watchdog.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         rr_ptr_r      <= '0;
         grant_id_r    <= '0;
         tx_data_r     <= '0;
         req_ready_r   <= '0;
         req_done_r    <= '0;
         tx_start_r    <= 1'b0;
         busy_r        <= 1'b0;
         timeout_err_r <= 1'b0;
         wd_cnt_r      <= '0;
      end else begin
         tx_start_r    <= 1'b0;
         req_ready_r   <= '0;
         req_done_r    <= '0;
         timeout_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  state_r     <= LAUNCH;
                  grant_id_r  <= winner_s;
                  tx_data_r   <= sel_data_s;
                  tx_start_r  <= 1'b1;
                  req_ready_r <= winner_hot_s;
                  busy_r      <= 1'b1;
               end
            end
            LAUNCH: begin
               // tx_done here is spurious and deliberately ignored.
               state_r  <= WAIT_DONE;
               wd_cnt_r <= '0;
            end
            WAIT_DONE: begin
               // tx_done has priority over a simultaneous watchdog expiry.
               if (bus.tx_done) begin
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                  req_done_r <= grant_hot_s;
                  rr_ptr_r   <= next_ptr_s;
               end else if (WD_EN && (wd_cnt_r == WD_LAST)) begin
                  state_r       <= IDLE;
                  busy_r        <= 1'b0;
                  timeout_err_r <= 1'b1;
                  rr_ptr_r      <= next_ptr_s;
               end else if (wd_cnt_r != WD_MAX) begin
                  wd_cnt_r <= wd_cnt_r + WD_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_r;
   assign bus.req_done    = req_done_r;
   assign bus.tx_start    = tx_start_r;
   assign bus.tx_data     = tx_data_r;
   assign bus.busy        = busy_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench: dut_a (4 requesters, 16-cycle watchdog) runs directed
// and random frames against a transaction-level round-robin model; dut_b
// (3 requesters, watchdog disabled) covers wrap-around on a non-power-of-2 ring.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   import uart_ctrl_pkg::*;

   localparam int NA  = 4;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic reset;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus_a ();
   uart_tx_arbiter_if #(.NUM_REQ(3), .DATA_W(8)) bus_b ();

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(TMO)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .TIMEOUT_CYC(0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   logic [3:0]  valid_a;
   logic [7:0]  byte_a [4];
   logic        done_a;
   logic [2:0]  valid_b;
   logic [23:0] data_b;
   logic        done_b;

   assign bus_a.req_valid = valid_a;
   assign bus_a.req_data  = {byte_a[3], byte_a[2], byte_a[1], byte_a[0]};
   assign bus_a.tx_done   = done_a;
   assign bus_b.req_valid = valid_b;
   assign bus_b.req_data  = data_b;
   assign bus_b.tx_done   = done_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mdl_ptr;
   int exp_w;
   logic [7:0] exp_d;
   int start_cyc;
   int prev_cyc;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first valid index scanning p, p+1, ... mod NA.
   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < NA; k++) begin
         int idx;
         logic [3:0] m;
         idx = (p + k) % NA;
         m = v >> idx;
         if (m[0]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] onehot(input int i);
      return 4'b0001 << i;
   endfunction

   task automatic rst_checks(input string tag);
      chk({tag, "_start"},   bus_a.tx_start,    0);
      chk({tag, "_ready"},   bus_a.req_ready,   0);
      chk({tag, "_rdone"},   bus_a.req_done,    0);
      chk({tag, "_data"},    bus_a.tx_data,     0);
      chk({tag, "_busy"},    bus_a.busy,        0);
      chk({tag, "_grant"},   bus_a.grant_id,    0);
      chk({tag, "_timeout"}, bus_a.timeout_err, 0);
   endtask

   // Called in an IDLE cycle with a non-empty valid_a; ends in WAIT_DONE cycle 0.
   task automatic launch_a(input bit keep, input bit spur);
      exp_w = pick(valid_a, mdl_ptr);
      exp_d = byte_a[2'(exp_w)];
      @(posedge clk); #1;
      chk("a_start",   bus_a.tx_start,  1);
      chk("a_ready",   bus_a.req_ready, onehot(exp_w));
      chk("a_grant",   bus_a.grant_id,  exp_w);
      chk("a_data",    bus_a.tx_data,   exp_d);
      chk("a_busy",    bus_a.busy,      1);
      chk("a_rdone_1", bus_a.req_done,  0);
      chk("a_to_1",    bus_a.timeout_err, 0);
      start_cyc = cyc;
      if (!keep) valid_a[2'(exp_w)] = 1'b0;
      done_a = spur;
      @(posedge clk); #1;
      done_a = 1'b0;
      chk("a_start_1cyc", bus_a.tx_start,  0);
      chk("a_ready_1cyc", bus_a.req_ready, 0);
   endtask

   // tx_done in WAIT_DONE cycle d (d<0: never); ends in the following IDLE cycle.
   task automatic wait_a(input int d);
      int  end_c;
      bit  to;
      to    = (d < 0) || (d >= TMO);
      end_c = to ? TMO : d + 1;
      for (int c = 0; c < end_c; c++) begin
         chk("a_wait_busy",  bus_a.busy,        1);
         chk("a_wait_rdone", bus_a.req_done,    0);
         chk("a_wait_to",    bus_a.timeout_err, 0);
         chk("a_wait_data",  bus_a.tx_data,     exp_d);
         for (int i = 0; i < NA; i++) begin
            if (!valid_a[2'(i)]) byte_a[2'(i)] = 8'($urandom);
         end
         done_a = (c == d);
         @(posedge clk); #1;
      end
      done_a = 1'b0;
      chk("a_end_rdone", bus_a.req_done,    to ? 4'b0000 : onehot(exp_w));
      chk("a_end_to",    bus_a.timeout_err, to);
      chk("a_end_busy",  bus_a.busy,        0);
      chk("a_end_grant", bus_a.grant_id,    exp_w);
      mdl_ptr = (exp_w + 1) % NA;
   endtask

   initial begin
      reset   = 1'b0;
      valid_a = 4'b0000;
      done_a  = 1'b0;
      for (int i = 0; i < NA; i++) byte_a[i] = 8'h00;
      valid_b = 3'b000;
      data_b  = 24'h000000;
      done_b  = 1'b0;

      // Reset state
      #2 reset = 1'b1;
      #1 rst_checks("rst0");
      chk("rst0_b_busy", bus_b.busy, 0);
      @(posedge clk); @(posedge clk); #1;
      reset   = 1'b0;
      mdl_ptr = 0;
      @(posedge clk); #1;

      // Spurious tx_done while idle
      done_a = 1'b1;
      @(posedge clk); #1;
      done_a = 1'b0;
      chk("spur_idle_busy",  bus_a.busy,     0);
      chk("spur_idle_rdone", bus_a.req_done, 0);
      chk("spur_idle_start", bus_a.tx_start, 0);

      // Single request from 2, spurious tx_done in LAUNCH
      byte_a[2] = 8'hA5;
      valid_a   = 4'b0100;
      launch_a(1'b0, 1'b1);
      chk("single_data", bus_a.tx_data, 8'hA5);
      wait_a(9);
      chk("single_grant", bus_a.grant_id, 2);

      // Fairness from a fresh pointer
      reset = 1'b1;
      #1 rst_checks("rst1");
      @(posedge clk); #1;
      reset   = 1'b0;
      mdl_ptr = 0;
      for (int i = 0; i < NA; i++) byte_a[i] = 8'h10 + 8'(i);
      valid_a = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         prev_cyc = start_cyc;
         launch_a(1'b1, 1'b0);
         chk("fair_grant", bus_a.grant_id, n % 4);
         chk("fair_data",  bus_a.tx_data,  8'h10 + 8'(n % 4));
         if (n > 0) chk("fair_spacing", start_cyc - prev_cyc, 5 + 3);
         wait_a(5);
      end
      valid_a = 4'b0000;

      // Timeout on requester 1, pointer moves to 2
      valid_a = 4'b0010;
      launch_a(1'b0, 1'b0);
      wait_a(-1);
      valid_a = 4'b0110;
      launch_a(1'b0, 1'b0);
      chk("to_ptr_grant", bus_a.grant_id, 2);
      wait_a(3);
      valid_a = 4'b0000;
      // tx_done on the last watchdog cycle wins
      valid_a = 4'b0010;
      launch_a(1'b0, 1'b0);
      wait_a(TMO - 1);

      // Reset in the middle of WAIT_DONE
      valid_a = 4'b0100;
      launch_a(1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1 rst_checks("rst_mid");
      @(posedge clk); #1;
      reset   = 1'b0;
      mdl_ptr = 0;
      for (int c = 0; c < TMO + 4; c++) begin
         chk("post_rst_rdone", bus_a.req_done,    0);
         chk("post_rst_to",    bus_a.timeout_err, 0);
         chk("post_rst_busy",  bus_a.busy,        0);
         @(posedge clk); #1;
      end
      byte_a[3] = 8'h5C;
      valid_a   = 4'b1000;
      launch_a(1'b0, 1'b0);
      chk("post_rst_grant3", bus_a.grant_id, 3);
      wait_a(4);

      // Randomized traffic against the model
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NA; i++) begin
            if (!valid_a[2'(i)] && ($urandom_range(0, 1) == 1)) begin
               valid_a[2'(i)] = 1'b1;
               byte_a[2'(i)]  = 8'($urandom);
            end else if (valid_a[2'(i)] && ($urandom_range(0, 7) == 0)) begin
               valid_a[2'(i)] = 1'b0;
            end
         end
         if (valid_a == 4'b0000) begin
            @(posedge clk); #1;
            chk("rnd_idle_busy",  bus_a.busy,     0);
            chk("rnd_idle_start", bus_a.tx_start, 0);
         end else begin
            launch_a(1'b0, 1'($urandom_range(0, 1)));
            wait_a(int'($urandom_range(0, 20)));
         end
      end
      valid_a = 4'b0000;
      @(posedge clk); #1;

      // Three requesters, watchdog disabled, wrap-around
      data_b  = {8'h33, 8'h22, 8'h11};
      chk("b_idle_busy", bus_b.busy, 0);
      valid_b = 3'b010;
      @(posedge clk); #1;
      chk("b1_start", bus_b.tx_start,  1);
      chk("b1_ready", bus_b.req_ready, 3'b010);
      chk("b1_grant", bus_b.grant_id,  1);
      chk("b1_data",  bus_b.tx_data,   8'h22);
      valid_b = 3'b000;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         chk("b_nowd_to",   bus_b.timeout_err, 0);
         chk("b_nowd_busy", bus_b.busy,        1);
      end
      done_b = 1'b1;
      @(posedge clk); #1;
      done_b = 1'b0;
      chk("b1_rdone", bus_b.req_done, 3'b010);
      chk("b1_idle",  bus_b.busy,     0);
      valid_b = 3'b011;
      @(posedge clk); #1;
      chk("b_wrap_grant", bus_b.grant_id,  0);
      chk("b_wrap_ready", bus_b.req_ready, 3'b001);
      chk("b_wrap_data",  bus_b.tx_data,   8'h11);
      valid_b = 3'b010;
      @(posedge clk); #1;
      done_b = 1'b1;
      @(posedge clk); #1;
      done_b = 1'b0;
      chk("b0_rdone", bus_b.req_done, 3'b001);
      @(posedge clk); #1;
      chk("b_next_grant", bus_b.grant_id,  1);
      chk("b_next_ready", bus_b.req_ready, 3'b010);
      chk("b_next_data",  bus_b.tx_data,   8'h22);
      valid_b = 3'b000;
      @(posedge clk); #1;
      done_b = 1'b1;
      @(posedge clk); #1;
      done_b = 1'b0;
      chk("b1b_rdone", bus_b.req_done, 3'b010);
      repeat (3) @(posedge clk);
      #1;
      chk("b_hold_grant", bus_b.grant_id, 1);
      chk("b_hold_data",  bus_b.tx_data,  8'h22);
      chk("b_hold_busy",  bus_b.busy,     0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
